operand_fetch: RTL and testbench



---
 rtl/operand_fetch_if.sv | 77 +++++++
 rtl/operand_fetch.sv | 125 ++++++++++++
 tb/tb_operand_fetch.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// ---------------------------------------------------------------------------
// operand_fetch_if
//   Bundles every non-clock signal of the operand fetch stage.
//   slave  : the operand_fetch stage itself.
//   master : the surroundings (decode, register file, writeback, execute).
//
//   Decode side    : in_valid/in_ready handshake, in_op, in_src1..3, in_use,
//                    in_dst, in_wr
//   Reg file side  : get_num1..3 (read indices), reg_out1..3 (read data)
//   Writeback side : wb_enable, wb_num, wb_val
//   Control        : flush (discard the execute-bound slot)
//   Execute side   : ex_valid/ex_ready handshake, ex_op, ex_val1..3,
//                    ex_dst, ex_wr
// ---------------------------------------------------------------------------
interface operand_fetch_if #(
    parameter int WORD_SIZE = 32,
    parameter int REG_INDEX = 5,
    parameter int OP_SIZE   = 6
);
    // decode -> stage
    logic                 in_valid;
    logic                 in_ready;
    logic [OP_SIZE-1:0]   in_op;
    logic [REG_INDEX-1:0] in_src1;
    logic [REG_INDEX-1:0] in_src2;
    logic [REG_INDEX-1:0] in_src3;
    logic [2:0]           in_use;
    logic [REG_INDEX-1:0] in_dst;
    logic                 in_wr;

    // stage <-> register file read ports
    logic [REG_INDEX-1:0] get_num1;
    logic [REG_INDEX-1:0] get_num2;
    logic [REG_INDEX-1:0] get_num3;
    logic [WORD_SIZE-1:0] reg_out1;
    logic [WORD_SIZE-1:0] reg_out2;
    logic [WORD_SIZE-1:0] reg_out3;

    // writeback (shared with the register file write port)
    logic [REG_INDEX-1:0] wb_num;
    logic [WORD_SIZE-1:0] wb_val;
    logic                 wb_enable;

    logic                 flush;

    // stage -> execute
    logic                 ex_valid;
    logic                 ex_ready;
    logic [OP_SIZE-1:0]   ex_op;
    logic [WORD_SIZE-1:0] ex_val1;
    logic [WORD_SIZE-1:0] ex_val2;
    logic [WORD_SIZE-1:0] ex_val3;
    logic [REG_INDEX-1:0] ex_dst;
    logic                 ex_wr;

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_src3, in_use, in_dst, in_wr,
        input  reg_out1, reg_out2, reg_out3,
        input  wb_num, wb_val, wb_enable,
        input  flush,
        input  ex_ready,
        output in_ready,
        output get_num1, get_num2, get_num3,
        output ex_valid, ex_op, ex_val1, ex_val2, ex_val3, ex_dst, ex_wr
    );

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_src3, in_use, in_dst, in_wr,
        output reg_out1, reg_out2, reg_out3,
        output wb_num, wb_val, wb_enable,
        output flush,
        output ex_ready,
        input  in_ready,
        input  get_num1, get_num2, get_num3,
        input  ex_valid, ex_op, ex_val1, ex_val2, ex_val3, ex_dst, ex_wr
    );
endinterface

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//   Sits between decode and execute. Drives the register file read indices
//   straight from the decoded sources, forwards a same-cycle writeback over
//   the (not yet updated) register file data, and latches op/operands/dst
//   into a single execute-bound slot. A busy bit per register blocks issue
//   while an older writer of a needed register is still in flight
//   (RAW on sources, WAW on the destination).
//
//   clk           : rising-edge clock
//   reset_enable  : synchronous, active-high reset
//   bus (slave)   : decode, register file, writeback, flush and execute
//                   signals; see operand_fetch_if
// ---------------------------------------------------------------------------
module operand_fetch #(
    parameter int WORD_SIZE     = 32,
    parameter int REG_INDEX     = 5,
    parameter int REG_FILE_SIZE = 32,
    parameter int OP_SIZE       = 6
) (
    input  logic            clk,
    input  logic            reset_enable,
    operand_fetch_if.slave  bus
);
    localparam int NUM_SRC = 3;

    // execute slot
    logic                     r_ex_valid;
    logic [OP_SIZE-1:0]       r_ex_op;
    logic [NUM_SRC-1:0][WORD_SIZE-1:0] r_ex_val;
    logic [REG_INDEX-1:0]     r_ex_dst;
    logic                     r_ex_wr;

    // one pending-writer bit per architectural register
    logic [REG_FILE_SIZE-1:0] r_busy;
    logic [REG_FILE_SIZE-1:0] w_busy_nxt;

    logic [NUM_SRC-1:0][REG_INDEX-1:0] w_src;
    logic [NUM_SRC-1:0][WORD_SIZE-1:0] w_rd;
    logic [NUM_SRC-1:0][WORD_SIZE-1:0] w_fwd;
    logic [NUM_SRC-1:0]                w_raw;

    logic w_dst_wb_hit;
    logic w_waw;
    logic w_slot_free;
    logic w_in_ready;
    logic w_accept;

    assign w_src = {bus.in_src3, bus.in_src2, bus.in_src1};
    assign w_rd  = {bus.reg_out3, bus.reg_out2, bus.reg_out1};

    // read indices go out unconditionally so the data is ready in this cycle
    assign bus.get_num1 = bus.in_src1;
    assign bus.get_num2 = bus.in_src2;
    assign bus.get_num3 = bus.in_src3;

    // Per-source forward mux and RAW check. A writeback landing on the
    // register this cycle both supplies the value (the register file only
    // updates at the edge) and retires the busy bit, so it never stalls.
    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
            logic w_wb_hit;
            assign w_wb_hit = bus.wb_enable && (bus.wb_num == w_src[k]);
            assign w_fwd[k] = w_wb_hit ? bus.wb_val : w_rd[k];
            assign w_raw[k] = bus.in_use[k] && r_busy[w_src[k]] && !w_wb_hit;
        end
    endgenerate

    assign w_dst_wb_hit = bus.wb_enable && (bus.wb_num == bus.in_dst);
    assign w_waw        = bus.in_wr && r_busy[bus.in_dst] && !w_dst_wb_hit;

    assign w_slot_free = !r_ex_valid || bus.ex_ready;
    assign w_in_ready  = w_slot_free && !(|w_raw) && !w_waw
                         && !bus.flush && !reset_enable;
    assign w_accept    = bus.in_valid && w_in_ready;

    assign bus.in_ready = w_in_ready;

    // Order matters: the accept set is applied last so that a writer issued
    // in the same cycle its predecessor retires keeps the register busy.
    // A flushed writer never reaches writeback, so its bit is dropped here.
    // Accept cannot coincide with flush, so those two never collide.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.wb_enable)
            w_busy_nxt[bus.wb_num] = 1'b0;
        if (bus.flush && r_ex_valid && r_ex_wr)
            w_busy_nxt[r_ex_dst] = 1'b0;
        if (w_accept && bus.in_wr)
            w_busy_nxt[bus.in_dst] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset_enable) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_val   <= '0;
            r_ex_dst   <= '0;
            r_ex_wr    <= 1'b0;
            r_busy     <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_accept) begin
                r_ex_valid <= 1'b1;
                r_ex_op    <= bus.in_op;
                r_ex_val   <= w_fwd;
                r_ex_dst   <= bus.in_dst;
                r_ex_wr    <= bus.in_wr;
            end else if (bus.flush || bus.ex_ready) begin
                // consumed or discarded with nothing new behind it;
                // data fields keep their last value, only valid drops
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign bus.ex_valid = r_ex_valid;
    assign bus.ex_op    = r_ex_op;
    assign bus.ex_val1  = r_ex_val[0];
    assign bus.ex_val2  = r_ex_val[1];
    assign bus.ex_val3  = r_ex_val[2];
    assign bus.ex_dst   = r_ex_dst;
    assign bus.ex_wr    = r_ex_wr;

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
//   Directed stimulus with literal expectations at key points, plus a
//   behavioural model (register file array, busy set, one execute slot)
//   checked against the DUT at every falling edge.
// ---------------------------------------------------------------------------
module tb_operand_fetch;
    logic clk;
    logic reset_enable;
    int   total = 0;
    int   bad   = 0;

    operand_fetch_if #(.WORD_SIZE(32), .REG_INDEX(5), .OP_SIZE(6)) bus ();

    operand_fetch #(
        .WORD_SIZE(32), .REG_INDEX(5), .REG_FILE_SIZE(32), .OP_SIZE(6)
    ) dut (
        .clk          (clk),
        .reset_enable (reset_enable),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bench register file: reset contents r1=5, r2=7, others 0x100+i
    logic [31:0] regs [32];
    always @(posedge clk) begin
        if (reset_enable) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= (i == 1) ? 32'd5 : (i == 2) ? 32'd7 : 32'h100 + 32'(i);
        end else if (bus.wb_enable) begin
            regs[bus.wb_num] <= bus.wb_val;
        end
    end
    assign bus.reg_out1 = regs[bus.in_src1];
    assign bus.reg_out2 = regs[bus.in_src2];
    assign bus.reg_out3 = regs[bus.in_src3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_busy;
    logic        m_ev;
    logic [5:0]  m_op;
    logic [31:0] m_v [3];
    logic [4:0]  m_dst;
    logic        m_wr;
    bit          m_known = 0;

    function automatic logic [4:0] src_of(input int k);
        case (k)
            0:       return bus.in_src1;
            1:       return bus.in_src2;
            default: return bus.in_src3;
        endcase
    endfunction

    // register still owed by an in-flight writer after this cycle
    function automatic logic pending(input logic [4:0] r);
        return m_busy[r] && !(bus.wb_enable && bus.wb_num == r);
    endfunction

    function automatic logic exp_ready();
        logic stall;
        stall = 1'b0;
        for (int k = 0; k < 3; k++)
            if (bus.in_use[k] && pending(src_of(k))) stall = 1'b1;
        if (bus.in_wr && pending(bus.in_dst)) stall = 1'b1;
        return !reset_enable && !bus.flush && (!m_ev || bus.ex_ready) && !stall;
    endfunction

    // compare current DUT state, then predict state after the next edge
    always @(negedge clk) begin
        logic        acc;
        logic [31:0] nb;
        if (m_known) begin
            check("m_in_ready", bus.in_ready, exp_ready());
            check("m_get_num", {bus.get_num3, bus.get_num2, bus.get_num1},
                  {bus.in_src3, bus.in_src2, bus.in_src1});
            check("m_ex_valid", bus.ex_valid, m_ev);
            check("m_busy", dut.r_busy, m_busy);
            if (m_ev) begin
                check("m_ex_op", bus.ex_op, m_op);
                check("m_ex_val1", bus.ex_val1, m_v[0]);
                check("m_ex_val2", bus.ex_val2, m_v[1]);
                check("m_ex_val3", bus.ex_val3, m_v[2]);
                check("m_ex_dst", bus.ex_dst, m_dst);
                check("m_ex_wr", bus.ex_wr, m_wr);
            end
        end
        if (reset_enable) begin
            m_busy = '0; m_ev = 0; m_op = '0; m_dst = '0; m_wr = 0;
            for (int k = 0; k < 3; k++) m_v[k] = '0;
            m_known = 1;
        end else if (m_known) begin
            acc = bus.in_valid && exp_ready();
            nb  = m_busy;
            if (bus.wb_enable) nb[bus.wb_num] = 1'b0;
            if (bus.flush && m_ev && m_wr) nb[m_dst] = 1'b0;
            if (acc) begin
                m_op = bus.in_op;
                for (int k = 0; k < 3; k++)
                    m_v[k] = (bus.wb_enable && bus.wb_num == src_of(k)) ? bus.wb_val
                                                                         : regs[src_of(k)];
                m_dst = bus.in_dst;
                m_wr  = bus.in_wr;
                if (bus.in_wr) nb[bus.in_dst] = 1'b1;
                m_ev = 1'b1;
            end else if (bus.flush || bus.ex_ready) begin
                m_ev = 1'b0;
            end
            m_busy = nb;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] use_, input logic [4:0] dst, input logic wr);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = s1;
        bus.in_src2  = s2;
        bus.in_src3  = 5'd0;
        bus.in_use   = use_;
        bus.in_dst   = dst;
        bus.in_wr    = wr;
    endtask

    initial begin
        reset_enable  = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_src1   = '0;
        bus.in_src2   = '0;
        bus.in_src3   = '0;
        bus.in_use    = '0;
        bus.in_dst    = '0;
        bus.in_wr     = 1'b0;
        bus.wb_num    = '0;
        bus.wb_val    = '0;
        bus.wb_enable = 1'b0;
        bus.flush     = 1'b0;
        bus.ex_ready  = 1'b1;

        cyc(); cyc(); settle();
        check("rst_in_ready", bus.in_ready, 0);
        reset_enable = 1'b0;
        settle();
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_busy", dut.r_busy, 0);

        // independent issue: r1 + r2 -> r3
        issue(6'h11, 5'd1, 5'd2, 3'b011, 5'd3, 1'b1);
        settle();
        check("ind_ready", bus.in_ready, 1);
        cyc();
        // dependent on r3: stalls until r3 writes back
        issue(6'h12, 5'd3, 5'd0, 3'b001, 5'd5, 1'b1);
        settle();
        check("ind_ex_valid", bus.ex_valid, 1);
        check("ind_ex_val1", bus.ex_val1, 5);
        check("ind_ex_val2", bus.ex_val2, 7);
        check("ind_busy3", dut.r_busy[3], 1);
        check("raw_stall0", bus.in_ready, 0);
        cyc(); settle();
        check("raw_stall1", bus.in_ready, 0);
        cyc();
        bus.wb_enable = 1'b1; bus.wb_num = 5'd3; bus.wb_val = 32'd12;
        settle();
        check("raw_wb_ready", bus.in_ready, 1);
        cyc();
        bus.wb_enable = 1'b0;
        issue(6'h03, 5'd0, 5'd0, 3'b000, 5'd4, 1'b1);
        settle();
        check("raw_fwd_val1", bus.ex_val1, 12);
        check("raw_ex_op", bus.ex_op, 6'h12);
        check("raw_busy3", dut.r_busy[3], 0);
        check("raw_busy5", dut.r_busy[5], 1);
        check("waw_first_ready", bus.in_ready, 1);
        cyc();
        // second writer of r4 while the first retires in the same cycle
        issue(6'h04, 5'd0, 5'd0, 3'b000, 5'd4, 1'b1);
        bus.wb_enable = 1'b1; bus.wb_num = 5'd4; bus.wb_val = 32'd44;
        settle();
        check("waw_setclr_ready", bus.in_ready, 1);
        cyc();
        bus.wb_enable = 1'b0;
        issue(6'h05, 5'd0, 5'd0, 3'b000, 5'd4, 1'b1);
        settle();
        check("waw_busy4", dut.r_busy[4], 1);
        check("waw_ex_op", bus.ex_op, 6'h04);
        check("waw_stall", bus.in_ready, 0);
        cyc(); settle();
        check("waw_stall1", bus.in_ready, 0);
        bus.wb_enable = 1'b1; bus.wb_num = 5'd4; bus.wb_val = 32'd9;
        settle();
        check("waw_release", bus.in_ready, 1);
        cyc();

        // back-pressure
        bus.wb_enable = 1'b0;
        bus.ex_ready  = 1'b0;
        issue(6'h07, 5'd1, 5'd0, 3'b001, 5'd7, 1'b0);
        settle();
        check("bp_ready0", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            check("bp_hold_op", bus.ex_op, 6'h05);
            check("bp_hold_valid", bus.ex_valid, 1);
            check("bp_ready", bus.in_ready, 0);
        end
        bus.ex_ready = 1'b1;
        settle();
        check("bp_release", bus.in_ready, 1);
        cyc(); settle();
        check("bp_load_op", bus.ex_op, 6'h07);
        check("bp_load_val", bus.ex_val1, 5);

        // back-to-back independent issue
        for (int i = 0; i < 4; i++) begin
            issue(6'h20 + 6'(i), 5'd2, 5'd0, 3'b001, 5'd10 + 5'(i), 1'b1);
            settle();
            check("b2b_ready", bus.in_ready, 1);
            cyc();
        end
        bus.in_valid = 1'b0;
        settle();
        check("b2b_last_op", bus.ex_op, 6'h23);
        check("b2b_last_val", bus.ex_val1, 7);
        cyc();

        // flush a writer of r6
        bus.ex_ready = 1'b0;
        issue(6'h08, 5'd0, 5'd0, 3'b000, 5'd6, 1'b1);
        cyc();
        issue(6'h09, 5'd0, 5'd0, 3'b000, 5'd8, 1'b1);
        bus.flush = 1'b1;
        settle();
        check("fl_ready", bus.in_ready, 0);
        check("fl_busy6_before", dut.r_busy[6], 1);
        cyc();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.ex_ready = 1'b1;
        settle();
        check("fl_ex_valid", bus.ex_valid, 0);
        check("fl_busy6", dut.r_busy[6], 0);
        check("fl_busy8", dut.r_busy[8], 0);

        // reset mid-operation
        issue(6'h0a, 5'd0, 5'd0, 3'b000, 5'd9, 1'b1);
        cyc();
        issue(6'h0b, 5'd0, 5'd0, 3'b000, 5'd14, 1'b1);
        reset_enable = 1'b1;
        settle();
        check("mr_ready", bus.in_ready, 0);
        check("mr_ex_valid_pre", bus.ex_valid, 1);
        cyc(); settle();
        check("mr_ex_valid", bus.ex_valid, 0);
        check("mr_ex_op", bus.ex_op, 0);
        check("mr_ex_val1", bus.ex_val1, 0);
        check("mr_ex_dst", bus.ex_dst, 0);
        check("mr_ex_wr", bus.ex_wr, 0);
        check("mr_busy", dut.r_busy, 0);
        reset_enable = 1'b0;
        bus.in_valid = 1'b0;
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
